// File: rtl/lsu_ctrl_if.sv
// Bundle of the CPU request/response handshake and the data-memory port used by lsu_ctrl.
// Handshake: a request transfers on the rising edge where req_valid && req_ready; the requester keeps req_* stable until then. resp_valid is a one-cycle pulse and cannot be stalled.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-3:0] dm_a;
  logic [31:0]       dm_wd;
  logic              dm_we;
  logic [31:0]       dm_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, dm_a, dm_wd, dm_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, dm_a, dm_wd, dm_we
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sub-word loads with sign/zero extension and sub-word stores
// by read-modify-write against a 32-word memory with asynchronous read.
module lsu_ctrl #(
  parameter int ADDR_W = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_ctrl_if.slave   bus,
  output logic [2:0]  dbg_state
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        size_q, lane_q;
  logic              uns_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-3:0] a_q;
  logic [31:0]       merged_q, rdata_q;
  logic              err_q;
  logic              accept, req_err;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_val, merge_val;

  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                   state_nxt = RESP;
          else if (!bus.req_we)          state_nxt = LOAD;
          else if (bus.req_size == 2'b10) state_nxt = WRITE;
          else                           state_nxt = RMW_RD;
        end
      end
      LOAD:    state_nxt = RESP;
      RMW_RD:  state_nxt = WRITE;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane extraction for loads and lane replacement for read-modify-write, both from dm_rd.
  always_comb begin
    byte_v    = bus.dm_rd[{lane_q, 3'b000} +: 8];
    half_v    = lane_q[1] ? bus.dm_rd[31:16] : bus.dm_rd[15:0];
    load_val  = bus.dm_rd;
    merge_val = bus.dm_rd;
    case (size_q)
      2'b00: begin
        load_val = {{24{~uns_q & byte_v[7]}}, byte_v};
        merge_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = {{16{~uns_q & half_v[15]}}, half_v};
        if (lane_q[1]) merge_val[31:16] = wdata_q;
        else           merge_val[15:0]  = wdata_q;
      end
      default: begin
        load_val  = bus.dm_rd;
        merge_val = bus.dm_rd;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      size_q   <= 2'b00;
      lane_q   <= 2'b00;
      uns_q    <= 1'b0;
      wdata_q  <= 16'h0;
      a_q      <= '0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            size_q  <= bus.req_size;
            lane_q  <= bus.req_addr[1:0];
            uns_q   <= bus.req_unsigned;
            wdata_q <= bus.req_wdata[15:0];
            a_q     <= bus.req_addr[ADDR_W-1:2];
            if (req_err) begin
              rdata_q <= 32'h0;
              err_q   <= 1'b1;
            end else if (bus.req_we && bus.req_size == 2'b10) begin
              merged_q <= bus.req_wdata;
            end
          end
        end
        LOAD: begin
          rdata_q <= load_val;
          err_q   <= 1'b0;
        end
        RMW_RD: merged_q <= merge_val;
        WRITE: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.dm_we      = (state == WRITE);
  assign bus.dm_a       = a_q;
  assign bus.dm_wd      = merged_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign dbg_state      = state;
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 7, giving the byte-address width; the word address is ADDR_W-2 = 5 bits, matching the 32-word data memory.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have the port req_valid, input, 1 bit: CPU access request.
REQ-005 The block SHALL have the port req_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have the port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have the port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 The block SHALL have the port req_unsigned, input, 1 bit: zero-extend sub-word loads.
REQ-009 The block SHALL have the port req_addr, input, ADDR_W bits: byte address.
REQ-010 The block SHALL have the port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 The block SHALL have the port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have the port resp_rdata, output, 32 bits: load result.
REQ-013 The block SHALL have the port resp_err, output, 1 bit: request rejected (misaligned or illegal size).
REQ-014 The block SHALL have the port dm_a, output, 5 bits: data-memory word address.
REQ-015 The block SHALL have the port dm_wd, output, 32 bits: data-memory write data.
REQ-016 The block SHALL have the port dm_we, output, 1 bit: data-memory write enable.
REQ-017 The block SHALL have the port dm_rd, input, 32 bits: data-memory asynchronous read data.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, RMW_RD, WRITE and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on the rising edge where req_valid && req_ready, and all req_* fields are latched at that edge.
REQ-020 Transitions from IDLE on acceptance SHALL be: error -> RESP; load -> LOAD; word store -> WRITE; byte/half store -> RMW_RD.
REQ-021 Transitions SHALL continue LOAD -> RESP, RMW_RD -> WRITE, WRITE -> RESP, RESP -> IDLE, each unconditional after one cycle.
REQ-022 An error SHALL be: size 11; half with addr[0]=1; word with addr[1:0]!=00. Errors perform no memory access.
REQ-023 dm_a SHALL equal latched addr[ADDR_W-1:2] (registered at acceptance) and hold until the next acceptance.
REQ-024 dm_we SHALL be 1 iff state==WRITE, giving exactly one write cycle per store and never for loads or errors.
REQ-025 Lanes SHALL be little-endian: byte lane = addr[1:0]; halfword lane = addr[1] (0 = bits 15:0, 1 = bits 31:16).
REQ-026 In RMW_RD the block SHALL register dm_rd with the addressed lane(s) replaced by req_wdata[7:0] or [15:0]; other bytes SHALL be preserved unchanged.
REQ-027 For a word store, the merged word SHALL equal req_wdata.
REQ-028 dm_wd SHALL output the merged word register.
REQ-029 In LOAD the block SHALL register the extracted lane, sign-extended from bit 7/15 unless latched unsigned=1; words pass unchanged.
REQ-030 resp_valid SHALL be 1 iff state==RESP.
REQ-031 resp_err SHALL be valid with resp_valid.
REQ-032 resp_rdata SHALL be 0 for stores and errors; it holds its value until the next RESP.
REQ-033 Latency, counted in cycles after the acceptance cycle until resp_valid, SHALL be: error 1, load 2, word store 2, sub-word store 3.
REQ-034 Responses SHALL have no backpressure.
REQ-035 req_valid while not IDLE SHALL be ignored; the requester holds it until accepted.
REQ-036 Back-to-back requests SHALL be possible: the next acceptance can occur in the cycle after RESP.

Reset
REQ-037 When rst_n=0 at a rising edge the block SHALL set: state IDLE, dm_a=0, dm_wd=0, resp_rdata=0, resp_err=0, latched fields 0.
REQ-038 The resulting reset outputs SHALL be req_ready=1, resp_valid=0, dm_we=0.
REQ-039 Reset mid-operation SHALL abort the access with no response.
REQ-040 A write already in WRITE at the reset edge SHALL complete in memory at that edge; no write SHALL occur afterwards.
REQ-041 Requests presented while rst_n=0 SHALL not be accepted.

Verification
REQ-042 The bench SHALL cover reset: rst_n=0 for 2 cycles -> req_ready=1, resp_valid=0, dm_we=0, dm_a=0, dm_wd=0.
REQ-043 The bench SHALL cover a word store: addr 0x08, data 0xDEADBEEF -> dm_we=1 for one cycle with dm_a=2, dm_wd=0xDEADBEEF; resp_valid at +2, resp_err=0.
REQ-044 The bench SHALL cover a byte store: memory word 2 = 0x11223344; store byte 0xA5 to addr 0x0A -> RMW_RD then write 0x11A53344; resp_valid at +3.
REQ-045 The bench SHALL cover halfword loads: word 2 = 0x80017FFF; signed half load at addr 0x0A -> resp_rdata=0xFFFF8001; unsigned load -> 0x00008001; addr 0x08 signed -> 0x00007FFF.
REQ-046 The bench SHALL cover a misaligned access: word load at addr 0x05 -> resp_valid at +1, resp_err=1, resp_rdata=0, dm_we never asserted.
REQ-047 The bench SHALL cover reset mid-RMW: rst_n=0 while in RMW_RD -> dm_we stays 0, memory unchanged, no resp_valid, req_ready=1 after the edge.
